arb_lane_issue_buffer: RTL

Requester-side companion to the round-robin arbiter. It holds per-lane (per-warp) pending request payloads in small FIFOs and drives the `req` vector into the arbiter. It consumes the arbiter's one-hot grant, pops the granted lane's head entry and presents it downstream on a registered valid/ready output. It sits between the warp-issue logic and the shared execution or memory port that the arbiter guards.

---
 rtl/arb_lane_issue_buffer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/arb_lane_issue_buffer.sv
// arb_lane_issue_buffer
// Requester-side companion to the round-robin arbiter. Each lane owns a small
// FIFO of pending payloads. A lane requests the arbiter whenever it holds an
// entry and the registered output stage can take a new one. A legal one-hot
// grant pops that lane's head into the output stage on the next edge. An
// illegal grant sets a sticky error flag and is otherwise ignored.
//
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   in_valid      per-lane enqueue strobe (dropped while the lane is full)
//   in_data       lane i payload at [i*DATAW +: DATAW]
//   in_ready      per-lane FIFO not full (combinational from state)
//   req           per-lane request to the arbiter (combinational)
//   grant_oh      one-hot grant from the arbiter, all-zero = no grant
//   out_valid     registered output holds a granted entry
//   out_data      granted payload
//   out_lane      index of the granted lane
//   out_ready     downstream accepts out_data this cycle
//   protocol_err  sticky flag, set on an illegal grant
module arb_lane_issue_buffer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DATAW = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in_valid,
  input  logic [WIDTH*DATAW-1:0]   in_data,
  output logic [WIDTH-1:0]         in_ready,
  output logic [WIDTH-1:0]         req,
  input  logic [WIDTH-1:0]         grant_oh,
  output logic                     out_valid,
  output logic [DATAW-1:0]         out_data,
  output logic [$clog2(WIDTH)-1:0] out_lane,
  input  logic                     out_ready,
  output logic                     protocol_err
);

  localparam int unsigned LW = $clog2(WIDTH);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DATAW-1:0] mem  [WIDTH][DEPTH];
  logic [PW-1:0]    wptr [WIDTH];
  logic [PW-1:0]    rptr [WIDTH];
  logic [CW-1:0]    cnt  [WIDTH];

  logic [WIDTH-1:0] push;
  logic [WIDTH-1:0] pop;
  logic             stage_free;
  logic             accept;
  logic             illegal;
  logic [LW-1:0]    grant_idx;
  logic [DATAW-1:0] grant_data;

  // Per-lane readiness, requests and push qualification.
  always_comb begin : lane_status
    stage_free = !out_valid || out_ready;
    in_ready   = '0;
    req        = '0;
    push       = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      in_ready[i] = (cnt[i] != CW'(DEPTH));
      req[i]      = (cnt[i] != '0) && stage_free;
      push[i]     = in_valid[i] && in_ready[i];
    end
  end

  // Grant qualification and one-hot to index/head-data mux.
  // The OR-reduction is only meaningful when accept is true (exactly one bit).
  always_comb begin : grant_decode
    accept     = $onehot(grant_oh) && ((grant_oh & req) == grant_oh);
    illegal    = (grant_oh != '0) && !accept;
    pop        = accept ? grant_oh : '0;
    grant_idx  = '0;
    grant_data = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (grant_oh[i]) begin
        grant_idx  = grant_idx | LW'(i);
        grant_data = grant_data | mem[i][rptr[i]];
      end
    end
  end

  // Payload storage; contents are don't-care while a lane is empty.
  always_ff @(posedge clk) begin : fifo_mem
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (push[i]) begin
        mem[i][wptr[i]] <= in_data[i*DATAW +: DATAW];
      end
    end
  end

  // FIFO pointers and occupancy; push+pop leaves cnt unchanged.
  always_ff @(posedge clk or posedge reset) begin : fifo_ctrl
    if (reset) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (push[i]) begin
          wptr[i] <= wptr[i] + PW'(1);
        end
        if (pop[i]) begin
          rptr[i] <= rptr[i] + PW'(1);
        end
        case ({push[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + CW'(1);
          2'b01:   cnt[i] <= cnt[i] - CW'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // Output stage: load on accept, drain on handshake, otherwise hold.
  // An illegal grant never loads; a pending handshake still drains.
  always_ff @(posedge clk or posedge reset) begin : out_stage
    if (reset) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_lane     <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_lane  <= grant_idx;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (illegal) begin
        protocol_err <= 1'b1;
      end
    end
  end

endmodule
